dual_mac_sequencer: RTL and testbench
=====================================

Name: dual_mac_sequencer

Overview:
- Controller that sequences the packed dual-weight int8 MAC datapath across a whole layer.
- On `start` it walks NUM_NEURONS/2 neuron pairs. Neuron 2p is the top (T) weight row and neuron 2p+1 the bottom (B) row.
- For each pair it streams NUM_INPUTS elements from the external input and weight memories (1-cycle read latency) and accumulates both dot products.
- Each pair's result is emitted over a valid/ready interface. The block sits between the input/weight RAMs and the downstream activation stage.

Parameters:
- WIDTH, 8, element width of inputs and weights.
- NUM_INPUTS, 1024, dot-product length (>=2).
- NUM_NEURONS, 16, neurons per layer; must be even, otherwise $error at elaboration.
- SIGN, 1, 1 = signed operands, 0 = unsigned.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a layer; sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted until return to IDLE.
- done  out  1  one-cycle pulse after the final pair's handshake.
- in_addr  out  $clog2(NUM_INPUTS)  input-memory address.
- in_data  in  WIDTH  input-memory read data, valid 1 cycle after address.
- w_addr  out  $clog2(NUM_NEURONS/2*NUM_INPUTS)  weight address = pair*NUM_INPUTS + k.
- w_t_data  in  WIDTH  top weight, 1-cycle latency.
- w_b_data  in  WIDTH  bottom weight, 1-cycle latency.
- out_valid  out  1  result pair available.
- out_ready  in  1  downstream accepts.
- out_pair  out  $clog2(NUM_NEURONS/2)  pair index of the presented result.
- out_t  out  ACC_W  signed top dot product.
- out_b  out  ACC_W  signed bottom dot product.

Behaviour:
- ACC_W:
  - SIGN=1: $clog2(NUM_INPUTS*2**(2*WIDTH-2)+1)+1. Default is 26, so an all −128·−128 sum of 2^24 fits.
  - SIGN=0: $clog2(NUM_INPUTS*(2**WIDTH-1)**2+1)+1, zero-extended.
  - No overflow is possible by construction.
- Reset values: busy=0, done=0, out_valid=0, out_t=0, out_b=0, out_pair=0, in_addr=0, w_addr=0, accumulators cleared, state IDLE.
- States: IDLE -> ISSUE -> DRAIN -> EMIT -> (ISSUE | FINISH) -> IDLE.
- IDLE:
  - On start, go to ISSUE with pair=0, k=0 and clear accumulators.
  - start in any other state is ignored.
- ISSUE:
  - Present in_addr=k and w_addr=pair*NUM_INPUTS+k each cycle, k = 0..NUM_INPUTS-1.
  - A delayed-valid flag enables accumulation of in_data*w_t_data and in_data*w_b_data one cycle later.
  - After k=NUM_INPUTS-1, go to DRAIN.
- DRAIN: one cycle; the last product is accumulated; go to EMIT.
- EMIT:
  - Hold out_valid=1 with out_t, out_b and out_pair registered and stable until out_ready.
  - On handshake, clear the accumulators and k=0.
  - If pair<NUM_NEURONS/2-1, increment pair and go to ISSUE; otherwise go to FINISH.
- FINISH: done=1 for one cycle; busy drops the following cycle; go to IDLE.
- Latency, with start accepted at cycle 0:
  - addresses occupy cycles 1..NUM_INPUTS;
  - out_valid first high at cycle NUM_INPUTS+2;
  - the next pair's ISSUE begins the cycle after the handshake.
- in_addr wraps to 0 at every pair boundary.
- Backpressure: out_ready low stalls in EMIT indefinitely; no memory reads are issued while stalled.
- Reset in any state: next cycle matches the reset values; partial sums are discarded; no done pulse.

Optional Feature:
- DUAL_MAC_RELU_EN defined: out_t and out_b are clamped to 0 when negative (ReLU applied at the EMIT register load); out_pair and timing are unchanged.
- Undefined: raw signed sums are emitted.

Decomposition:
- Package dual_mac_pkg:
  - state enum (IDLE, ISSUE, DRAIN, EMIT, FINISH);
  - function acc_width(WIDTH, NUM_INPUTS, SIGN) returning ACC_W.
- Sub-module dual_mac_lane:
  - shared-input two-accumulator MAC;
  - ports: clk, reset, clr, en, x, w_t, w_b, acc_t, acc_b;
  - sign handling per SIGN.
- The sequencer holds only the FSM, counters, address generation and output register.

Test Plan:
- Defaults; all inputs=1, all w_t=2, all w_b=−3 -> pair 0: out_t=2048, out_b=−3072, out_valid at cycle 1026. Eight pairs emitted, out_pair 0..7, then one done pulse.
- All inputs=−128, all weights=−128 -> out_t=out_b=16777216, no wrap. With SIGN=0, all 255 -> 66585600.
- out_ready held low 5 cycles in EMIT -> out_valid, out_t and out_b stable, in_addr/w_addr frozen. Accept on cycle 6; next pair begins the following cycle.
- reset asserted during ISSUE at k=500 -> next cycle busy=0 and out_valid=0. A new start yields correct sums, with no residue from the aborted pair.
- start pulsed while busy -> ignored: pair count still 8, single done.
- DUAL_MAC_RELU_EN defined, w_b=−3 case -> out_b=0, out_t=2048; same with the macro undefined -> out_b=−3072.

Source files
------------

// File: rtl/dual_mac_pkg.sv
// Shared types and width helpers for the dual-weight MAC sequencer.
package dual_mac_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    DRAIN,
    EMIT,
    FINISH
  } state_t;

  typedef longint unsigned u64_t;

  // Accumulator width large enough that a full-length dot product can never wrap.
  function automatic int acc_width(int width, int num_inputs, int sign);
    u64_t full;
    u64_t mag;
    full = (u64_t'(1) << width) - u64_t'(1);
    if (sign != 0) begin
      mag = u64_t'(num_inputs) << (2 * width - 2);
    end else begin
      mag = u64_t'(num_inputs) * full * full;
    end
    return $clog2(mag + u64_t'(1)) + 1;
  endfunction

  function automatic int index_width(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dual_mac_sequencer_if.sv
// Memory-read and result-stream signals between the sequencer, the input/weight RAMs and the activation stage.
interface dual_mac_sequencer_if
  import dual_mac_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int NUM_INPUTS  = 1024,
  parameter int NUM_NEURONS = 16,
  parameter int SIGN        = 1
);

  localparam int ACC_W  = acc_width(WIDTH, NUM_INPUTS, SIGN);
  localparam int IN_AW  = index_width(NUM_INPUTS);
  localparam int W_AW   = index_width(NUM_NEURONS / 2 * NUM_INPUTS);
  localparam int PAIR_W = index_width(NUM_NEURONS / 2);

  logic [IN_AW-1:0]         in_addr;
  logic [WIDTH-1:0]         in_data;
  logic [W_AW-1:0]          w_addr;
  logic [WIDTH-1:0]         w_t_data;
  logic [WIDTH-1:0]         w_b_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [PAIR_W-1:0]        out_pair;
  logic signed [ACC_W-1:0]  out_t;
  logic signed [ACC_W-1:0]  out_b;

  modport master (
    output in_addr, w_addr, out_valid, out_pair, out_t, out_b,
    input  in_data, w_t_data, w_b_data, out_ready
  );

  modport slave (
    input  in_addr, w_addr, out_valid, out_pair, out_t, out_b,
    output in_data, w_t_data, w_b_data, out_ready
  );

endinterface

// File: rtl/dual_mac_lane.sv
// Shared-input MAC with two accumulators (top and bottom weight rows).
module dual_mac_lane
  import dual_mac_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int NUM_INPUTS = 1024,
  parameter int SIGN       = 1,
  localparam int ACC_W     = acc_width(WIDTH, NUM_INPUTS, SIGN)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clr,
  input  logic                    en,
  input  logic [WIDTH-1:0]        x,
  input  logic [WIDTH-1:0]        w_t,
  input  logic [WIDTH-1:0]        w_b,
  output logic signed [ACC_W-1:0] acc_t,
  output logic signed [ACC_W-1:0] acc_b
);

  localparam bit SX = (SIGN != 0);

  logic signed [ACC_W-1:0] x_ext;
  logic signed [ACC_W-1:0] wt_ext;
  logic signed [ACC_W-1:0] wb_ext;

  // Operands are widened to the accumulator width so the product needs no further extension.
  assign x_ext  = {{(ACC_W - WIDTH){SX & x[WIDTH-1]}}, x};
  assign wt_ext = {{(ACC_W - WIDTH){SX & w_t[WIDTH-1]}}, w_t};
  assign wb_ext = {{(ACC_W - WIDTH){SX & w_b[WIDTH-1]}}, w_b};

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      acc_t <= '0;
      acc_b <= '0;
    end else if (en) begin
      acc_t <= acc_t + x_ext * wt_ext;
      acc_b <= acc_b + x_ext * wb_ext;
    end
  end

endmodule

// File: rtl/dual_mac_sequencer.sv
// Walks all neuron pairs of a layer through the dual MAC lane and streams each pair's sums out.
// Define DUAL_MAC_RELU_EN to clamp negative results to zero on output.
module dual_mac_sequencer
  import dual_mac_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int NUM_INPUTS  = 1024,
  parameter int NUM_NEURONS = 16,
  parameter int SIGN        = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  dual_mac_sequencer_if.master bus
);

  localparam int ACC_W     = acc_width(WIDTH, NUM_INPUTS, SIGN);
  localparam int IN_AW     = index_width(NUM_INPUTS);
  localparam int W_AW      = index_width(NUM_NEURONS / 2 * NUM_INPUTS);
  localparam int PAIR_W    = index_width(NUM_NEURONS / 2);
  localparam int NUM_PAIRS = NUM_NEURONS / 2;

  if ((NUM_NEURONS % 2) != 0) begin : g_odd_neurons
    $error("dual_mac_sequencer: NUM_NEURONS must be even");
  end

  state_t                  state;
  state_t                  state_next;
  logic [IN_AW-1:0]        k;
  logic [W_AW-1:0]         w_addr;
  logic [PAIR_W-1:0]       pair;
  logic                    valid_d;
  logic                    acc_clr;
  logic                    last_k;
  logic                    last_pair;
  logic signed [ACC_W-1:0] acc_t;
  logic signed [ACC_W-1:0] acc_b;

  assign last_k    = (k == IN_AW'(NUM_INPUTS - 1));
  assign last_pair = (pair == PAIR_W'(NUM_PAIRS - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next    = state;
    acc_clr       = 1'b0;
    busy          = (state != IDLE);
    done          = (state == FINISH);
    bus.out_valid = (state == EMIT);
    case (state)
      IDLE: begin
        if (start) begin
          state_next = ISSUE;
          acc_clr    = 1'b1;
        end
      end
      ISSUE:  if (last_k) state_next = DRAIN;
      DRAIN:  state_next = EMIT;
      EMIT: begin
        if (bus.out_ready) begin
          acc_clr    = 1'b1;
          state_next = last_pair ? FINISH : ISSUE;
        end
      end
      FINISH: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // w_addr simply counts through the weight rows, so it already sits on the next pair's base after ISSUE.
  always_ff @(posedge clk) begin
    if (reset) begin
      k       <= '0;
      w_addr  <= '0;
      pair    <= '0;
      valid_d <= 1'b0;
    end else begin
      valid_d <= (state == ISSUE);
      case (state)
        IDLE: begin
          if (start) begin
            k      <= '0;
            w_addr <= '0;
            pair   <= '0;
          end
        end
        ISSUE: begin
          k      <= last_k ? '0 : k + IN_AW'(1);
          w_addr <= w_addr + W_AW'(1);
        end
        EMIT: begin
          if (bus.out_ready && !last_pair) begin
            pair <= pair + PAIR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  dual_mac_lane #(
    .WIDTH      (WIDTH),
    .NUM_INPUTS (NUM_INPUTS),
    .SIGN       (SIGN)
  ) u_lane (
    .clk   (clk),
    .reset (reset),
    .clr   (acc_clr),
    .en    (valid_d),
    .x     (bus.in_data),
    .w_t   (bus.w_t_data),
    .w_b   (bus.w_b_data),
    .acc_t (acc_t),
    .acc_b (acc_b)
  );

  assign bus.in_addr  = k;
  assign bus.w_addr   = w_addr;
  assign bus.out_pair = pair;

  // The lane accumulators are frozen throughout EMIT, so they serve directly as the result register.
`ifdef DUAL_MAC_RELU_EN
  assign bus.out_t = acc_t[ACC_W-1] ? '0 : acc_t;
  assign bus.out_b = acc_b[ACC_W-1] ? '0 : acc_b;
`else
  assign bus.out_t = acc_t;
  assign bus.out_b = acc_b;
`endif

endmodule

// File: tb/tb_dual_mac_sequencer.sv
// Scoreboard bench for dual_mac_sequencer: directed layers, backpressure, mid-layer reset, ignored start.
// Expected results follow DUAL_MAC_RELU_EN when it is defined.
module tb_dual_mac_sequencer;

  localparam int NUM_INPUTS = 1024;
  localparam int NUM_PAIRS  = 8;

  typedef enum {MEM_CONST, MEM_PATTERN} mem_mode_t;

  typedef struct {
    int     pair;
    longint t;
    longint b;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic busy;
  logic done;
  logic start_u;
  logic busy_u;
  logic done_u;

  mem_mode_t   mode;
  logic [7:0]  c_in;
  logic [7:0]  c_t;
  logic [7:0]  c_b;

  exp_t exp_q[$];
  exp_t exp_u_q[$];
  int   errors      = 0;
  int   checks      = 0;
  int   done_seen   = 0;
  int   done_u_seen = 0;
  int   emitted     = 0;
  bit   sim_end     = 1'b0;

  dual_mac_sequencer_if #(.WIDTH(8), .NUM_INPUTS(NUM_INPUTS), .NUM_NEURONS(16), .SIGN(1)) bus ();
  dual_mac_sequencer_if #(.WIDTH(8), .NUM_INPUTS(NUM_INPUTS), .NUM_NEURONS(2), .SIGN(0)) bus_u ();

  dual_mac_sequencer #(.WIDTH(8), .NUM_INPUTS(NUM_INPUTS), .NUM_NEURONS(16), .SIGN(1)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .busy  (busy),
    .done  (done),
    .bus   (bus)
  );

  dual_mac_sequencer #(.WIDTH(8), .NUM_INPUTS(NUM_INPUTS), .NUM_NEURONS(2), .SIGN(0)) dut_u (
    .clk   (clk),
    .reset (reset),
    .start (start_u),
    .busy  (busy_u),
    .done  (done_u),
    .bus   (bus_u)
  );

  always #5 clk = ~clk;

  // Input/weight RAM models with one cycle of read latency.
  always @(posedge clk) begin
    if (mode == MEM_CONST) begin
      bus.in_data  <= c_in;
      bus.w_t_data <= c_t;
      bus.w_b_data <= c_b;
    end else begin
      bus.in_data  <= {6'd0, bus.in_addr[1:0]};
      bus.w_t_data <= bus.w_addr[0] ? 8'd1 : ({5'd0, bus.w_addr[12:10]} + 8'd1);
      bus.w_b_data <= (bus.w_addr[1:0] == 2'd3) ? (8'd0 - {5'd0, bus.w_addr[12:10]}) : 8'd0;
    end
    bus_u.in_data  <= 8'hFF;
    bus_u.w_t_data <= 8'hFF;
    bus_u.w_b_data <= 8'hFF;
  end

  function automatic longint relu(longint v);
`ifdef DUAL_MAC_RELU_EN
    return (v < 0) ? 64'sd0 : v;
`else
    return v;
`endif
  endfunction

  task automatic checkOutput(input string name, input logic signed [63:0] actual,
                             input logic signed [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pattern mode sums: in[k]=k%4, w_t=(k even ? p+1 : 1), w_b=(k%4==3 ? -p : 0).
  task automatic applyStimulus(input mem_mode_t m, input int ci, input int ct, input int cb,
                               input bit push_exp);
    mode = m;
    c_in = 8'(ci);
    c_t  = 8'(ct);
    c_b  = 8'(cb);
    if (push_exp) begin
      for (int p = 0; p < NUM_PAIRS; p++) begin
        exp_t e;
        e.pair = p;
        if (m == MEM_CONST) begin
          e.t = relu(longint'(NUM_INPUTS) * ci * ct);
          e.b = relu(longint'(NUM_INPUTS) * ci * cb);
        end else begin
          e.t = relu(longint'(512 * p + 1536));
          e.b = relu(longint'(-768 * p));
        end
        exp_q.push_back(e);
      end
    end
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_seen < target && n < 12000) begin
      step();
      n++;
    end
    checkOutput("done_pulse", done_seen, target);
    checkOutput("busy_after_done", busy, 0);
    repeat (3) step();
    checkOutput("single_done", done_seen, target);
    checkOutput("queue_drained", exp_q.size(), 0);
    checkOutput("pairs_emitted", emitted, target * NUM_PAIRS);
  endtask

  initial begin
    reset         = 1'b1;
    start         = 1'b0;
    start_u       = 1'b0;
    bus.out_ready = 1'b1;
    bus_u.out_ready = 1'b1;
    mode          = MEM_CONST;
    c_in          = 8'd0;
    c_t           = 8'd0;
    c_b           = 8'd0;
    fork
      begin : stim
        int cyc;
        int n;
        repeat (3) step();
        reset = 1'b0;
        step();
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_out_valid", bus.out_valid, 0);
        checkOutput("rst_out_t", bus.out_t, 0);
        checkOutput("rst_out_b", bus.out_b, 0);
        checkOutput("rst_out_pair", bus.out_pair, 0);
        checkOutput("rst_in_addr", bus.in_addr, 0);
        checkOutput("rst_w_addr", bus.w_addr, 0);
        checkOutput("rst_u_in_addr", bus_u.in_addr, 0);
        checkOutput("rst_u_w_addr", bus_u.w_addr, 0);

        // Basic layer plus the unsigned instance in parallel.
        exp_u_q.push_back('{pair: 0, t: 66585600, b: 66585600});
        start_u = 1'b1;
        applyStimulus(MEM_CONST, 1, 2, -3, 1'b1);
        start_u = 1'b0;
        checkOutput("busy_after_start", busy, 1);
        checkOutput("first_in_addr", bus.in_addr, 0);
        cyc = 1;
        while (!bus.out_valid && cyc < 2000) begin
          step();
          cyc++;
        end
        checkOutput("first_valid_cycle", cyc, NUM_INPUTS + 2);
        wait_done(1);
        checkOutput("u_queue_drained", exp_u_q.size(), 0);
        checkOutput("u_done_pulse", done_u_seen, 1);
        checkOutput("u_busy_idle", busy_u, 0);

        // Extreme signed operands.
        applyStimulus(MEM_CONST, -128, -128, -128, 1'b1);
        wait_done(2);

        // Hold off each result for five cycles, accept on the sixth.
        bus.out_ready = 1'b0;
        applyStimulus(MEM_PATTERN, 0, 0, 0, 1'b1);
        for (int p = 0; p < NUM_PAIRS; p++) begin
          n = 0;
          while (!bus.out_valid && n < 2000) begin
            step();
            n++;
          end
          checkOutput("reach_emit", bus.out_valid, 1);
          repeat (5) begin
            checkOutput("stall_in_addr", bus.in_addr, 0);
            step();
          end
          checkOutput("stall_valid_held", bus.out_valid, 1);
          bus.out_ready = 1'b1;
          step();
          bus.out_ready = 1'b0;
          if (p < NUM_PAIRS - 1) begin
            checkOutput("valid_drop", bus.out_valid, 0);
            checkOutput("next_in_addr", bus.in_addr, 0);
            checkOutput("next_w_addr", bus.w_addr, (p + 1) * NUM_INPUTS);
            step();
            checkOutput("next_in_addr1", bus.in_addr, 1);
            checkOutput("next_w_addr1", bus.w_addr, (p + 1) * NUM_INPUTS + 1);
          end else begin
            checkOutput("finish_done", done, 1);
            checkOutput("finish_busy", busy, 1);
          end
        end
        wait_done(3);
        bus.out_ready = 1'b1;

        // Abort a layer mid-pair, then rerun cleanly while poking start.
        applyStimulus(MEM_CONST, 1, 2, -3, 1'b0);
        n = 0;
        while (bus.in_addr != 10'd500 && n < 2000) begin
          step();
          n++;
        end
        checkOutput("reach_k500", bus.in_addr, 500);
        reset = 1'b1;
        step();
        reset = 1'b0;
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_out_valid", bus.out_valid, 0);
        checkOutput("abort_done", done, 0);
        checkOutput("abort_in_addr", bus.in_addr, 0);
        checkOutput("abort_w_addr", bus.w_addr, 0);
        checkOutput("abort_out_t", bus.out_t, 0);
        checkOutput("abort_out_b", bus.out_b, 0);
        checkOutput("abort_out_pair", bus.out_pair, 0);
        step();
        applyStimulus(MEM_PATTERN, 0, 0, 0, 1'b1);
        repeat (300) step();
        start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 2000) begin
          step();
          n++;
        end
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done(4);
        checkOutput("abort_no_done", done_seen, 4);
        sim_end = 1'b1;
      end
      begin : monitor
        while (!sim_end) begin
          @(negedge clk);
          if (!reset) begin
            if (done) done_seen++;
            if (done_u) done_u_seen++;
            if (bus.out_valid) begin
              if (exp_q.size() == 0) begin
                checkOutput("unexpected_output_pair", bus.out_pair, -1);
              end else begin
                checkOutput("out_pair", bus.out_pair, exp_q[0].pair);
                checkOutput("out_t", bus.out_t, exp_q[0].t);
                checkOutput("out_b", bus.out_b, exp_q[0].b);
                if (bus.out_ready) begin
                  void'(exp_q.pop_front());
                  emitted++;
                end
              end
            end
            if (bus_u.out_valid) begin
              if (exp_u_q.size() == 0) begin
                checkOutput("u_unexpected_output_pair", bus_u.out_pair, -1);
              end else begin
                checkOutput("u_out_pair", bus_u.out_pair, exp_u_q[0].pair);
                checkOutput("u_out_t", bus_u.out_t, exp_u_q[0].t);
                checkOutput("u_out_b", bus_u.out_b, exp_u_q[0].b);
                if (bus_u.out_ready) void'(exp_u_q.pop_front());
              end
            end
          end
        end
      end
    join
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
